// File: rtl/if_stage_reg.sv
// Instruction-fetch stage: program counter plus the IF/ID pipeline register.
// Define IF_STALL_CNT_EN to add the saturating load-use stall counter port stall_cnt.
module if_stage_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PCWr,
    input  logic             IFIDWr,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_pc,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      IFIDInstr,
    output logic [31:0]      IFIDPC4,
    output logic             IFIDValid,
    output logic [4:0]       IFIDRegRs,
    output logic [4:0]       IFIDRegRt
`ifdef IF_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4;
    logic        load_use_stall;

    // Two low address bits are dropped; the target is always word aligned.
    logic [1:0]  unused_redirect_lsb;
    assign unused_redirect_lsb = redirect_pc[1:0];

    assign pc_plus4       = pc_q + 32'd4;
    assign load_use_stall = !redirect_valid && !PCWr && !IFIDWr;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (redirect_valid) begin
            pc_d    = {redirect_pc[31:2], 2'b00};
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (!PCWr && !IFIDWr) begin
            pc_d = pc_q;
        end else if (!PCWr) begin
            // PC is held, so the slot must become a bubble or the instruction issues twice.
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (!IFIDWr) begin
            pc_d = pc_plus4;
        end else begin
            pc_d    = pc_plus4;
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= {RESET_PC[31:2], 2'b00};
            instr_q <= 32'h0;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign IFIDInstr = instr_q;
    assign IFIDPC4   = pc4_q;
    assign IFIDValid = valid_q;
    assign IFIDRegRs = instr_q[25:21];
    assign IFIDRegRt = instr_q[20:16];

`ifdef IF_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (load_use_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_stall;
    assign unused_stall = load_use_stall;
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_if_stage_reg.sv
// Bench for if_stage_reg: directed vector table, hand-written reset/counter sequences,
// then randomized traffic checked against a rule-level reference model.
module tb_if_stage_reg;

    logic        clk;
    logic        rst_n;
    logic        PCWr;
    logic        IFIDWr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] IFIDInstr;
    logic [31:0] IFIDPC4;
    logic        IFIDValid;
    logic [4:0]  IFIDRegRs;
    logic [4:0]  IFIDRegRt;
`ifdef IF_STALL_CNT_EN
    localparam int CNT_W = 2;
    logic [CNT_W-1:0] stall_cnt;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    if_stage_reg #(
        .RESET_PC(32'h0000_0000)
`ifdef IF_STALL_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .PCWr(PCWr),
        .IFIDWr(IFIDWr),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .IFIDInstr(IFIDInstr),
        .IFIDPC4(IFIDPC4),
        .IFIDValid(IFIDValid),
        .IFIDRegRs(IFIDRegRs),
        .IFIDRegRt(IFIDRegRt)
`ifdef IF_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // instruction memory: word at address A is 0x1000_0000 + A
    function automatic logic [31:0] imem_of(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction
    assign imem_rdata = imem_of(imem_addr);

    // reference model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid, m_pc4_known;
    int          m_cnt;

    task automatic model_edge(input logic r, pw, iw, rv, input logic [31:0] rpc);
        if (!r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_pc4_known = 1'b1; m_cnt = 0;
        end else if (rv) begin
            m_pc = rpc & 32'hFFFF_FFFC;
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_pc4_known = 1'b1;
        end else if (!pw && !iw) begin
            if (m_cnt < 3) m_cnt = m_cnt + 1;
        end else if (!pw) begin
            m_instr = 32'h0; m_valid = 1'b0; m_pc4_known = 1'b0;
        end else if (!iw) begin
            m_pc = m_pc + 32'd4;
        end else begin
            m_instr = imem_of(m_pc);
            m_pc4 = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc4_known = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // driver: apply inputs for one rising edge, update model, return at falling edge
    task automatic step(input logic r, pw, iw, rv, input logic [31:0] rpc);
        rst_n = r; PCWr = pw; IFIDWr = iw; redirect_valid = rv; redirect_pc = rpc;
        @(posedge clk);
        model_edge(r, pw, iw, rv, rpc);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, " imem_addr"}, imem_addr, m_pc);
        check({tag, " instr"}, IFIDInstr, m_instr);
        check({tag, " valid"}, {31'h0, IFIDValid}, {31'h0, m_valid});
        check({tag, " rs"}, {27'h0, IFIDRegRs}, {27'h0, m_instr[25:21]});
        check({tag, " rt"}, {27'h0, IFIDRegRt}, {27'h0, m_instr[20:16]});
        if (m_pc4_known) check({tag, " pc4"}, IFIDPC4, m_pc4);
`ifdef IF_STALL_CNT_EN
        check({tag, " stall_cnt"}, {30'h0, stall_cnt}, m_cnt);
`endif
    endtask

    typedef struct {
        logic        pw, iw, rv;
        logic [31:0] rpc;
        logic [31:0] e_addr, e_instr, e_pc4;
        logic        e_valid, chk_pc4;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1, 1, 0, 32'h0,         32'h4,         32'h1000_0000, 32'h4,  1, 1};
        tbl[1]  = '{1, 1, 0, 32'h0,         32'h8,         32'h1000_0004, 32'h8,  1, 1};
        tbl[2]  = '{0, 0, 0, 32'h0,         32'h8,         32'h1000_0004, 32'h8,  1, 1};
        tbl[3]  = '{1, 1, 0, 32'h0,         32'hC,         32'h1000_0008, 32'hC,  1, 1};
        tbl[4]  = '{0, 1, 0, 32'h0,         32'hC,         32'h0,         32'h0,  0, 0};
        tbl[5]  = '{1, 1, 0, 32'h0,         32'h10,        32'h1000_000C, 32'h10, 1, 1};
        tbl[6]  = '{1, 1, 0, 32'h0,         32'h14,        32'h1000_0010, 32'h14, 1, 1};
        tbl[7]  = '{0, 0, 1, 32'h43,        32'h40,        32'h0,         32'h0,  0, 1};
        tbl[8]  = '{1, 1, 0, 32'h0,         32'h44,        32'h1000_0040, 32'h44, 1, 1};
        tbl[9]  = '{1, 0, 0, 32'h0,         32'h48,        32'h1000_0040, 32'h44, 1, 1};
        tbl[10] = '{1, 1, 0, 32'h0,         32'h4C,        32'h1000_0048, 32'h4C, 1, 1};
        tbl[11] = '{1, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         32'h0,  0, 1};
        tbl[12] = '{1, 1, 0, 32'h0,         32'h0,         32'h0FFF_FFFC, 32'h0,  1, 1};
        tbl[13] = '{1, 1, 0, 32'h0,         32'h4,         32'h1000_0000, 32'h4,  1, 1};

        rst_n = 1'b0; PCWr = 1'b1; IFIDWr = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        @(negedge clk);

        // reset state
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        check("reset imem_addr", imem_addr, 32'h0);
        check("reset instr", IFIDInstr, 32'h0);
        check("reset pc4", IFIDPC4, 32'h0);
        check("reset valid", {31'h0, IFIDValid}, 32'h0);

        // directed vector table
        for (int i = 0; i < 14; i++) begin
            step(1, tbl[i].pw, tbl[i].iw, tbl[i].rv, tbl[i].rpc);
            check($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].e_addr);
            check($sformatf("vec%0d instr", i), IFIDInstr, tbl[i].e_instr);
            check($sformatf("vec%0d valid", i), {31'h0, IFIDValid}, {31'h0, tbl[i].e_valid});
            check($sformatf("vec%0d rs", i), {27'h0, IFIDRegRs}, {27'h0, tbl[i].e_instr[25:21]});
            check($sformatf("vec%0d rt", i), {27'h0, IFIDRegRt}, {27'h0, tbl[i].e_instr[20:16]});
            if (tbl[i].chk_pc4) check($sformatf("vec%0d pc4", i), IFIDPC4, tbl[i].e_pc4);
        end

        // reset asserted mid-stall with a redirect pending discards everything
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h80);
        check("midstall reset imem_addr", imem_addr, 32'h0);
        check("midstall reset instr", IFIDInstr, 32'h0);
        check("midstall reset pc4", IFIDPC4, 32'h0);
        check("midstall reset valid", {31'h0, IFIDValid}, 32'h0);
        check_model("midstall reset");

`ifdef IF_STALL_CNT_EN
        // counter saturates at 3, then reset clears it
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0);
            check($sformatf("stall_cnt after %0d stalls", i + 1), {30'h0, stall_cnt},
                  (i + 1 > 3) ? 32'd3 : i + 1);
        end
        step(0, 1, 1, 0, 0);
        check("stall_cnt cleared", {30'h0, stall_cnt}, 32'h0);
`endif

        // randomized traffic against the model
        step(0, 1, 1, 0, 0);
        for (int n = 0; n < 600; n++) begin
            int sel;
            logic pw, iw, rv, r;
            logic [31:0] rpc;
            sel = $urandom_range(0, 7);
            pw = (sel <= 4) || (sel == 7);
            iw = (sel <= 4) || (sel == 6);
            rv = ($urandom_range(0, 9) == 0);
            r  = ($urandom_range(0, 59) != 0);
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            step(r, pw, iw, rv, rpc);
            check_model($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/if_stage_reg.md
# if_stage_reg

Instruction-fetch stage and IF/ID pipeline register of the 5-stage pipelined CPU. Holds the program counter, drives the instruction-memory address, and latches the fetched instruction and PC+4 into IF/ID for decode. Consumes `PCWr`/`IFIDWr` from the load-use hazard detection unit and a redirect from branch/jump resolution. Produces the `IFIDRegRs`/`IFIDRegRt` fields the hazard unit compares.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- `CNT_W`, 16, width of the stall counter (only with `IF_STALL_CNT_EN`).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `PCWr`  in  1  PC write enable from the hazard unit; 0 = hold PC.
- `IFIDWr`  in  1  IF/ID write enable from the hazard unit; 0 = hold IF/ID.
- `redirect_valid`  in  1  taken branch/jump; the driver asserts it only for an unstalled instruction.
- `redirect_pc`  in  32  target PC; bits [1:0] ignored and forced to 0.
- `imem_addr`  out  32  instruction-memory address, equal to current PC (combinational).
- `imem_rdata`  in  32  instruction word, valid in the same cycle as `imem_addr` (asynchronous read).
- `IFIDInstr`  out  32  latched instruction; 32'h0 (nop) when a bubble is held.
- `IFIDPC4`  out  32  latched PC+4 of that instruction.
- `IFIDValid`  out  1  1 = IF/ID holds a real instruction; 0 = bubble.
- `IFIDRegRs`  out  5  `IFIDInstr[25:21]`, combinational.
- `IFIDRegRt`  out  5  `IFIDInstr[20:16]`, combinational.
- `stall_cnt`  out  CNT_W  stall-cycle count; present only with `IF_STALL_CNT_EN`.

## Operation
- State: `pc` (32), `IFIDInstr`, `IFIDPC4`, `IFIDValid`, plus optional `stall_cnt`.
- Reset (`rst_n`=0 at the edge): `pc`=`RESET_PC`, `IFIDInstr`=0, `IFIDPC4`=0, `IFIDValid`=0, `stall_cnt`=0. Reset overrides every other input. Reset asserted mid-stall or mid-redirect discards all in-flight state.
- Per-edge update, first matching rule applies:
  1. `redirect_valid`=1: `pc`←{`redirect_pc[31:2]`,2'b00}. IF/ID flushed: Instr=0, PC4=0, Valid=0. This applies regardless of `PCWr`/`IFIDWr`.
  2. `PCWr`=0 and `IFIDWr`=0 (load-use stall): `pc` and IF/ID both hold.
  3. `PCWr`=0 and `IFIDWr`=1: `pc` holds. IF/ID loads a bubble (Valid=0, Instr=0) so the held instruction is never issued twice.
  4. `PCWr`=1 and `IFIDWr`=0: `pc`←`pc`+4. IF/ID holds. This combination is not expected from the hazard unit, but it is defined.
  5. Otherwise: `pc`←`pc`+4, `IFIDInstr`←`imem_rdata`, `IFIDPC4`←`pc`+4, `IFIDValid`←1.
- Arithmetic: `pc`+4 is 32-bit unsigned and wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0000_0000), with no flag raised. `pc[1:0]` is always 0.

## Timing
- Fetch latency: 1 cycle. The instruction at PC X appears on `IFIDInstr` the cycle after `imem_addr`=X, if rule 5 fires.
- Stall: each cycle with `PCWr`=`IFIDWr`=0 extends the same IF/ID contents by one cycle. `imem_addr` stays constant.
- Redirect penalty: 1 bubble. The target is on `imem_addr` the cycle after `redirect_valid`, and its instruction reaches IF/ID one cycle later.
- Outputs are registered, except `imem_addr`, `IFIDRegRs` and `IFIDRegRt`, which are combinational from registers only (no input-to-output path).

## Configuration
- `IF_STALL_CNT_EN` defined: `stall_cnt` port exists.
  - Increments by 1 on each non-reset edge where rule 2 fires.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset.
- Undefined: the port, the register and the logic are absent. All other behaviour is identical.

## Test plan
- Reset then run: `rst_n`=0 for 2 cycles, release, `PCWr`=`IFIDWr`=1, imem returns 32'h1000_0000+addr. Required: `imem_addr` = 0, 4, 8, …; IF/ID Valid=0 in the first cycle, then Instr=32'h1000_0000 with PC4=4.
- Load-use stall: at PC=8, drive `PCWr`=`IFIDWr`=0 for 1 cycle. Required: `imem_addr` stays 8, IF/ID holds the PC=4 instruction for 2 cycles, then normal flow resumes with PC=8.
- Redirect during stall: `redirect_valid`=1, `redirect_pc`=32'h0000_0043, `PCWr`=0. Required: next `imem_addr`=32'h40, IFIDValid=0, IFIDInstr=0.
- Bubble insert: `PCWr`=0, `IFIDWr`=1 for 1 cycle. Required: IFIDValid=0 and PC held; the next cycle latches the instruction at the held PC exactly once.
- Wrap: redirect to 32'hFFFF_FFFC, then run. Required: next `imem_addr`=0, and the latched IFIDPC4=0.
- `IF_STALL_CNT_EN` with `CNT_W`=2: 5 stall cycles. Required: `stall_cnt`=3 (saturated); reset clears it to 0.
